rs232_rx: RTL and testbench
===========================

# rs232_rx

UART receiver for the RS-232 link: recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from an asynchronous, idle-high RxD line. It synchronises the line, samples it at 16x the baud rate from an internal phase-accumulator tick, majority-votes each bit and presents bytes on a one-cycle valid strobe. It is the receive-side counterpart of the team's transmitter and shares its FREQ/BAUD parameterisation, so both ends can be instantiated with the same constants.

## Interface
- FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bits/s.
- ACC_W, 16: oversampling accumulator width.
- CLK50MHZ  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- RxD  in  1  asynchronous serial line, idle high.
- RxD_data  out  8  last correctly framed byte; held until the next good frame.
- RxD_valid  out  1  one-cycle pulse: RxD_data updated this cycle.
- RxD_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- RxD_busy  out  1  high in any state other than IDLE.

## Operation
- Synchroniser: two flip-flops on RxD; both reset to 1. All decisions use the second-stage output (rxs).
- Oversample tick: free-running ACC_W-bit accumulator adds INC each clock; tick = carry out (one-cycle pulse). INC = round(BAUD*16*2^ACC_W/FREQ), evaluated without 32-bit overflow (2416 for defaults; tick every ~27.13 clocks).
- Tick counter cnt (4 bits) and bit index idx (3 bits) advance only on tick cycles.
- Majority vote: rxs captured on ticks cnt=7, 8, 9; bit value = majority of the three, decided on the cnt=9 tick.
- States:
  - IDLE: on a tick with rxs=0 -> START, cnt=0.
  - START: on the cnt=9 tick, vote=1 -> IDLE (glitch rejected, no strobe); vote=0 -> continue; on the cnt=15 tick -> DATA, idx=0.
  - DATA: vote shifted into an 8-bit shift register at bit position idx (LSB first); on the cnt=15 tick, idx=7 -> STOP, else idx+1.
  - STOP: on the cnt=9 tick, vote=1 -> RxD_data <= shift register, RxD_valid pulse, -> IDLE (early return at mid-stop for resync); vote=0 -> RxD_frame_err pulse, RxD_data unchanged, -> BREAK.
  - BREAK: on a tick with rxs=1 -> IDLE. Covers break conditions and long-low lines.
- cnt wraps 15 -> 0 on every bit boundary; it is cleared on entry to START.
- No receive FIFO; an unconsumed byte is overwritten by the next good frame without any flag.

## Timing
- Reset values: RxD_data=0x00, RxD_valid=0, RxD_frame_err=0, RxD_busy=0, state IDLE, accumulator=0, cnt=0, idx=0.
- RST asserted mid-frame aborts the frame on the next edge and produces no strobe.
- t0 is the tick on which IDLE sees rxs=0. Bit k (0 = start, 1..8 = data, 9 = stop) is sampled on ticks t0+16k+7..9.
- RxD_valid or RxD_frame_err is asserted on the cycle after tick t0+153 (~9.6 bit times); RxD_data changes in the same cycle as RxD_valid.
- Input-to-rxs latency is 2 clocks; start detection jitter is at most one tick period.
- RxD_busy rises on the cycle after t0 and falls when IDLE is re-entered.
- Next start bit is accepted from the first tick after the return to IDLE, so back-to-back frames with exactly one stop bit are received.
- Tolerates at least ±3% baud mismatch.
- RxD_valid and RxD_frame_err are never high in the same cycle.

## Test plan
- Frame 0x55 at 115200 baud, FREQ 50 MHz -> exactly one RxD_valid, RxD_data=0x55, no RxD_frame_err, RxD_busy low ~0.5 bit after the pulse.
- Back-to-back 0x00, 0xFF, 0xA5, one stop bit each, no gap -> three RxD_valid pulses with data in order.
- 150-clock low glitch on an idle line -> no strobe; RxD_busy pulses then returns to 0; a following 0x3C is received correctly.
- 0xA5 sent with stop bit low, line held low for 2 bit times, then 0x5A -> one RxD_frame_err pulse, RxD_data keeps its previous value, then RxD_valid with 0x5A.
- RST pulse during data bit 4 of 0x81 -> all outputs return to reset values, no strobe for the aborted frame; the next 0x7E is received.
- Transmitter bit period set +3% and then -3% from nominal, 256 random bytes each -> all bytes match and no frame errors.

Source files
------------

// File: rtl/rs232_rx.sv
// rs232_rx - UART receiver for 8N1 frames on an idle-high RS-232 line.
//
// The line is brought into the clock domain by a two-flop synchroniser and
// sampled at 16x the baud rate. The 16x tick comes from a free-running phase
// accumulator. Each bit is decided by a 2-of-3 vote over ticks 7, 8 and 9 of
// its bit period. Good bytes are presented on a one-cycle valid strobe. A low
// stop bit produces a one-cycle frame-error strobe instead.
//
// Parameters:
//   FREQ   system clock frequency in Hz
//   BAUD   line rate in bits/s
//   ACC_W  width of the oversampling phase accumulator
// Ports:
//   CLK50MHZ       in   system clock; all logic runs on the rising edge
//   RST            in   synchronous active-high reset
//   RxD            in   asynchronous serial line, idle high
//   RxD_data       out  [7:0] last correctly framed byte; held until the next good frame
//   RxD_valid      out  one-cycle pulse when RxD_data is updated
//   RxD_frame_err  out  one-cycle pulse when the stop bit is sampled low
//   RxD_busy       out  high whenever the receiver is not idle
module rs232_rx #(
    parameter int FREQ  = 50000000,
    parameter int BAUD  = 115200,
    parameter int ACC_W = 16
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_valid,
    output logic       RxD_frame_err,
    output logic       RxD_busy
);

    // Accumulator increment: round(BAUD*16*2^ACC_W/FREQ).
    // The arithmetic is done in 64 bits so the product cannot overflow.
    localparam logic [63:0] INC_64 =
        (((64'(BAUD) * 64'd16) << ACC_W) + 64'(FREQ / 2)) / 64'(FREQ);
    localparam logic [ACC_W-1:0] INC = INC_64[ACC_W-1:0];

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic             rx_meta_r;
    logic             rxs_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W:0]   acc_sum_s;
    logic             tick_s;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s, cnt_cur_s;
    logic [2:0]  idx_r, idx_s;
    logic [7:0]  shift_r, shift_s;
    logic [1:0]  smp_r, smp_s;
    logic        vote_s;
    logic [7:0]  data_r, data_s;
    logic        valid_r, valid_s;
    logic        ferr_r, ferr_s;
    logic        busy_r, busy_s;

    // Two-flop synchroniser. Both stages reset to the idle level.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= RxD;
            rxs_r     <= rx_meta_r;
        end
    end

    // The carry out of the phase accumulator is the 16x oversample tick.
    assign acc_sum_s = {1'b0, acc_r} + {1'b0, INC};
    assign tick_s    = acc_sum_s[ACC_W];

    // Free-running phase accumulator.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_sum_s[ACC_W-1:0];
        end
    end

    // Next-state logic. cnt_r holds the index of the last tick, so
    // cnt_cur_s is the index of the tick in progress. Entering START with
    // cnt_r = 0 makes the start-detect tick count as tick 0 of the start bit.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shift_s   = shift_r;
        smp_s     = smp_r;
        data_s    = data_r;
        valid_s   = 1'b0;
        ferr_s    = 1'b0;
        cnt_cur_s = cnt_r + 4'd1;
        vote_s    = maj3(smp_r[1], smp_r[0], rxs_r);

        if (tick_s) begin
            if (state_r != IDLE) begin
                cnt_s = cnt_cur_s;
                if (cnt_cur_s == 4'd7) begin
                    smp_s[0] = rxs_r;
                end else if (cnt_cur_s == 4'd8) begin
                    smp_s[1] = rxs_r;
                end else begin
                    smp_s = smp_r;
                end
            end else begin
                cnt_s = cnt_r;
            end

            case (state_r)
                IDLE: begin
                    if (!rxs_r) begin
                        state_s = START;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    // A start bit that votes high at mid-bit was a glitch.
                    if ((cnt_cur_s == 4'd9) && vote_s) begin
                        state_s = IDLE;
                    end else if (cnt_cur_s == 4'd15) begin
                        state_s = DATA;
                        idx_s   = 3'd0;
                    end else begin
                        state_s = START;
                    end
                end
                DATA: begin
                    if (cnt_cur_s == 4'd9) begin
                        shift_s[idx_r] = vote_s;
                    end else begin
                        shift_s = shift_r;
                    end
                    if (cnt_cur_s == 4'd15) begin
                        if (idx_r == 3'd7) begin
                            state_s = STOP;
                        end else begin
                            idx_s = idx_r + 3'd1;
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end
                STOP: begin
                    // Returning to IDLE at mid-stop lets the next start edge
                    // be caught even when frames are sent back to back.
                    if (cnt_cur_s == 4'd9) begin
                        if (vote_s) begin
                            data_s  = shift_r;
                            valid_s = 1'b1;
                            state_s = IDLE;
                        end else begin
                            ferr_s  = 1'b1;
                            state_s = BRK;
                        end
                    end else begin
                        state_s = STOP;
                    end
                end
                BRK: begin
                    // Wait for the line to go high again after a break or a
                    // long low period.
                    if (rxs_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s = BRK;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        busy_s = (state_s != IDLE);
    end

    // Receiver state and output registers.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            smp_r   <= 2'b11;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            smp_r   <= smp_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            ferr_r  <= ferr_s;
            busy_r  <= busy_s;
        end
    end

    assign RxD_data      = data_r;
    assign RxD_valid     = valid_r;
    assign RxD_frame_err = ferr_r;
    assign RxD_busy      = busy_r;

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx - directed self-checking bench for rs232_rx.
// It drives 8N1 frames with real-valued bit periods. A negedge monitor logs
// the valid, frame-error and busy activity, and the results are compared
// against hand-computed expectations.
`timescale 1ns/1ps
module tb_rs232_rx;

    localparam real BIT_NOM  = 1.0e9 / 115200.0;
    localparam real BIT_SLOW = BIT_NOM * 1.03;
    localparam real BIT_FAST = BIT_NOM * 0.97;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] got_q[$];
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int busy_cyc  = 0;

    logic [7:0] pat [3] = '{8'hC3, 8'h17, 8'hE8};

    rs232_rx #(.FREQ(50000000), .BAUD(115200), .ACC_W(16)) dut (
        .CLK50MHZ      (clk),
        .RST           (rst),
        .RxD           (rxd),
        .RxD_data      (rx_data),
        .RxD_valid     (rx_valid),
        .RxD_frame_err (rx_ferr),
        .RxD_busy      (rx_busy)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Log strobes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (rx_ferr) ferr_cnt <= ferr_cnt + 1;
        if (rx_valid && rx_ferr) both_cnt <= both_cnt + 1;
        if (rx_busy) busy_cyc <= busy_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_byte();
        if (got_q.size() > 0) return {24'd0, got_q.pop_front()};
        else return 32'hFFFF_FFFF;
    endfunction

    // One 8N1 frame. The line is left at the stop-bit level afterwards.
    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop);
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_ns);
        end
        rxd = stop;
        #(bit_ns);
    endtask

    initial begin
        #1900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0;
        int b0;

        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ferr", 32'(rx_ferr), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;
        #(BIT_NOM);

        // Single 0x55. No strobe before 9 bit times, and idle again by the end of the stop bit.
        fork
            send_byte(8'h55, BIT_NOM, 1'b1);
            begin
                #(9.0 * BIT_NOM);
                check("t1_no_early", 32'(got_q.size()), 32'd0);
                check("t1_busy_mid", 32'(rx_busy), 32'd1);
            end
        join
        check("t1_count", 32'(got_q.size()), 32'd1);
        check("t1_data", pop_byte(), 32'h55);
        check("t1_busy_end", 32'(rx_busy), 32'd0);
        check("t1_ferr", 32'(ferr_cnt), 32'd0);
        #(BIT_NOM);

        // Back-to-back frames with one stop bit each.
        send_byte(8'h00, BIT_NOM, 1'b1);
        send_byte(8'hFF, BIT_NOM, 1'b1);
        send_byte(8'hA5, BIT_NOM, 1'b1);
        #(BIT_NOM);
        check("t2_count", 32'(got_q.size()), 32'd3);
        check("t2_b0", pop_byte(), 32'h00);
        check("t2_b1", pop_byte(), 32'hFF);
        check("t2_b2", pop_byte(), 32'hA5);

        // 150-clock glitch must be rejected.
        b0 = busy_cyc;
        rxd = 1'b0;
        repeat (150) @(posedge clk);
        rxd = 1'b1;
        #(2.0 * BIT_NOM);
        check("t3_busy_seen", 32'(busy_cyc > b0), 32'd1);
        check("t3_no_strobe", 32'(got_q.size()), 32'd0);
        check("t3_busy_end", 32'(rx_busy), 32'd0);
        send_byte(8'h3C, BIT_NOM, 1'b1);
        #(BIT_NOM);
        check("t3_data", pop_byte(), 32'h3C);
        check("t3_out", 32'(rx_data), 32'h3C);

        // Bad stop bit followed by a long low line, then a good frame.
        f0 = ferr_cnt;
        send_byte(8'hA5, BIT_NOM, 1'b0);
        #(2.0 * BIT_NOM);
        rxd = 1'b1;
        #(BIT_NOM);
        check("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("t4_no_valid", 32'(got_q.size()), 32'd0);
        check("t4_data_held", 32'(rx_data), 32'h3C);
        send_byte(8'h5A, BIT_NOM, 1'b1);
        #(BIT_NOM);
        check("t4_data", pop_byte(), 32'h5A);
        check("t4_ferr_after", 32'(ferr_cnt - f0), 32'd1);

        // Reset during data bit 4 of 0x81, held until the frame has passed.
        fork
            send_byte(8'h81, BIT_NOM, 1'b1);
            begin
                #(5.5 * BIT_NOM);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("t5_rst_data", 32'(rx_data), 32'h00);
                check("t5_rst_valid", 32'(rx_valid), 32'd0);
                check("t5_rst_ferr", 32'(rx_ferr), 32'd0);
                check("t5_rst_busy", 32'(rx_busy), 32'd0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        #(BIT_NOM);
        check("t5_no_strobe", 32'(got_q.size()), 32'd0);
        send_byte(8'h7E, BIT_NOM, 1'b1);
        #(BIT_NOM);
        check("t5_data", pop_byte(), 32'h7E);

        // Baud mismatch of +3% and -3%, frames sent back to back.
        f0 = ferr_cnt;
        for (int i = 0; i < 3; i++) send_byte(pat[i], BIT_SLOW, 1'b1);
        #(BIT_NOM);
        for (int i = 0; i < 3; i++) check("t6_slow", pop_byte(), 32'(pat[i]));
        for (int i = 0; i < 3; i++) send_byte(pat[i], BIT_FAST, 1'b1);
        #(BIT_NOM);
        for (int i = 0; i < 3; i++) check("t6_fast", pop_byte(), 32'(pat[i]));
        check("t6_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t6_extra", 32'(got_q.size()), 32'd0);

        check("valid_ferr_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
